// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage. Captures the memory stage's decoded
// controls, drives the single register-file write port, and serialises a
// load-with-base-writeback into two consecutive writes (Rd, then Rn).
// Optional feature macro: WB_FORWARD_EN adds one-cycle-delayed fwd_* copies
// of the write port so decode can bypass a just-committed write.
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [REG_AW-1:0] rn_in,
  input  logic              rd_we,
  input  logic [1:0]        rd_src,
  input  logic              rn_we,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] link_value,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_out,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef WB_FORWARD_EN
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              pc_wr
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;
  localparam logic [REG_AW-1:0] PC_REG = REG_AW'(32'd15);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BASE = 1'b1
  } state_t;

  state_t              state_q;
  logic                flush_pend_q;

  // Stage register
  logic                valid_q;
  logic [REG_AW-1:0]   rd_q;
  logic [REG_AW-1:0]   rn_q;
  logic                rd_we_q;
  logic [1:0]          rd_src_q;
  logic                rn_we_q;
  logic [DATA_W-1:0]   alu_q;
  logic [DATA_W-1:0]   link_q;

  // Last written address/data, presented while no write is in progress
  logic [REG_AW-1:0]   last_addr_q;
  logic [DATA_W-1:0]   last_data_q;

  logic [DATA_W-1:0]   rd_data_s;
  logic                wr_en_s;
  logic [REG_AW-1:0]   wr_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic                stall_s;

  // Rd data source select; the reserved encoding falls back to the ALU result
  always_comb begin
    rd_data_s = alu_q;
    case (rd_src_q)
      SRC_ALU:  rd_data_s = alu_q;
      SRC_MEM:  rd_data_s = mem_rdata;
      SRC_LINK: rd_data_s = link_q;
      default:  rd_data_s = alu_q;
    endcase
  end

  // Write-port and stall decode from the FSM state and the stage register
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = last_addr_q;
    wr_data_s = last_data_q;
    stall_s   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (valid_q) begin
          if (rd_we_q) begin
            wr_en_s   = 1'b1;
            wr_addr_s = rd_q;
            wr_data_s = rd_data_s;
          end else if (rn_we_q) begin
            wr_en_s   = 1'b1;
            wr_addr_s = rn_q;
            wr_data_s = alu_q;
          end else begin
            wr_en_s   = 1'b0;
          end
          // Rd == Rn: the load data wins and the base write is dropped
          stall_s = rd_we_q & rn_we_q & (rd_q != rn_q);
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_BASE: begin
        wr_en_s   = 1'b1;
        wr_addr_s = rn_q;
        wr_data_s = alu_q;
        stall_s   = 1'b0;
      end
      default: begin
        wr_en_s = 1'b0;
        stall_s = 1'b0;
      end
    endcase
  end

  assign stall_out = stall_s;
  assign rf_we     = wr_en_s;
  assign rf_waddr  = wr_addr_s;
  assign rf_wdata  = wr_data_s;
  assign pc_wr     = wr_en_s & (wr_addr_s == PC_REG);

  // FSM, stage capture, flush tracking and write-port mirrors
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      rd_q         <= '0;
      rn_q         <= '0;
      rd_we_q      <= 1'b0;
      rd_src_q     <= 2'b00;
      rn_we_q      <= 1'b0;
      alu_q        <= '0;
      link_q       <= '0;
      last_addr_q  <= '0;
      last_data_q  <= '0;
`ifdef WB_FORWARD_EN
      fwd_valid    <= 1'b0;
      fwd_addr     <= '0;
      fwd_data     <= '0;
`endif
    end else begin
      case (state_q)
        ST_RUN:  state_q <= stall_s ? ST_BASE : ST_RUN;
        ST_BASE: state_q <= ST_RUN;
        default: state_q <= ST_RUN;
      endcase

      if (wr_en_s) begin
        last_addr_q <= wr_addr_s;
        last_data_q <= wr_data_s;
      end

      if (!stall_s) begin
        valid_q      <= in_valid & ~flush & ~flush_pend_q;
        rd_q         <= rd_in;
        rn_q         <= rn_in;
        rd_we_q      <= rd_we;
        rd_src_q     <= rd_src;
        rn_we_q      <= rn_we;
        alu_q        <= alu_result;
        link_q       <= link_value;
        flush_pend_q <= (state_q == ST_BASE) & flush;
      end else begin
        // Held instruction upstream: remember the flush for the next capture
        flush_pend_q <= flush_pend_q | flush;
      end

`ifdef WB_FORWARD_EN
      fwd_valid <= wr_en_s;
      fwd_addr  <= wr_addr_s;
      fwd_data  <= wr_data_s;
`endif
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed scoreboard bench for writeback_unit.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  rd_in = 4'd0;
  logic [3:0]  rn_in = 4'd0;
  logic        rd_we = 1'b0;
  logic [1:0]  rd_src = 2'b00;
  logic        rn_we = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] link_value = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        stall_out;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_wr;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  writeback_unit #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .rd_in(rd_in), .rn_in(rn_in), .rd_we(rd_we), .rd_src(rd_src),
    .rn_we(rn_we), .alu_result(alu_result), .link_value(link_value),
    .mem_rdata(mem_rdata), .stall_out(stall_out), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_FORWARD_EN
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
    .pc_wr(pc_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        pc;
    logic        rst_cyc;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  int   vectors = 0;
  int   fails   = 0;

  task automatic drive(input logic v, input logic fl, input logic [3:0] rd,
                       input logic [3:0] rn, input logic dwe, input logic [1:0] src,
                       input logic nwe, input logic [31:0] alu, input logic [31:0] lnk);
    in_valid = v; flush = fl; rd_in = rd; rn_in = rn; rd_we = dwe;
    rd_src = src; rn_we = nwe; alu_result = alu; link_value = lnk;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic expect_w(input logic we, input logic [3:0] a, input logic [31:0] d,
                          input logic st, input logic rc);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.stall = st;
    e.pc = we & (a == 4'd15); e.rst_cyc = rc;
    q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      vectors++; fails++;
      $error("FAIL %s scoreboard: got no expectation, expected one", tag);
    end else begin
      e = q.pop_front();
      vectors++;
      assert (rf_we === e.we) else begin fails++;
        $error("FAIL %s rf_we: got %b expected %b", tag, rf_we, e.we); end
      vectors++;
      assert (rf_waddr === e.addr) else begin fails++;
        $error("FAIL %s rf_waddr: got %0d expected %0d", tag, rf_waddr, e.addr); end
      vectors++;
      assert (rf_wdata === e.data) else begin fails++;
        $error("FAIL %s rf_wdata: got %h expected %h", tag, rf_wdata, e.data); end
      vectors++;
      assert (stall_out === e.stall) else begin fails++;
        $error("FAIL %s stall_out: got %b expected %b", tag, stall_out, e.stall); end
      vectors++;
      assert (pc_wr === e.pc) else begin fails++;
        $error("FAIL %s pc_wr: got %b expected %b", tag, pc_wr, e.pc); end
`ifdef WB_FORWARD_EN
      vectors++;
      assert (fwd_valid === (e.rst_cyc ? 1'b0 : prev.we)) else begin fails++;
        $error("FAIL %s fwd_valid: got %b expected %b", tag, fwd_valid, e.rst_cyc ? 1'b0 : prev.we); end
      vectors++;
      assert (fwd_addr === (e.rst_cyc ? 4'd0 : prev.addr)) else begin fails++;
        $error("FAIL %s fwd_addr: got %0d expected %0d", tag, fwd_addr, e.rst_cyc ? 4'd0 : prev.addr); end
      vectors++;
      assert (fwd_data === (e.rst_cyc ? 32'd0 : prev.data)) else begin fails++;
        $error("FAIL %s fwd_data: got %h expected %h", tag, fwd_data, e.rst_cyc ? 32'd0 : prev.data); end
`endif
      prev = e;
    end
  endtask

  // Clock edge, then present this cycle's memory data, then compare
  task automatic step(input logic [31:0] mrd, input string tag);
    @(posedge clk);
    #1;
    mem_rdata = mrd;
    #1;
    check(tag);
  endtask

  initial begin
    prev.we = 1'b0; prev.addr = 4'd0; prev.data = 32'd0;
    prev.stall = 1'b0; prev.pc = 1'b0; prev.rst_cyc = 1'b1;

    // Reset for two cycles
    rst = 1'b1; bubble();
    expect_w(1'b0, 4'd0, 32'd0, 1'b0, 1'b1); step(32'd0, "reset0");
    expect_w(1'b0, 4'd0, 32'd0, 1'b0, 1'b1); step(32'd0, "reset1");
    rst = 1'b0;

    // ADD r3
    drive(1'b1, 1'b0, 4'd3, 4'd0, 1'b1, 2'b00, 1'b0, 32'h10, 32'd0);
    expect_w(1'b1, 4'd3, 32'h10, 1'b0, 1'b0); step(32'd0, "add_r3");

    // LDR r2,[r5],#4: two writes, stall on the first
    drive(1'b1, 1'b0, 4'd2, 4'd5, 1'b1, 2'b01, 1'b1, 32'h104, 32'd0);
    expect_w(1'b1, 4'd2, 32'hDEADBEEF, 1'b1, 1'b0); step(32'hDEADBEEF, "ldr_rd");
    drive(1'b1, 1'b0, 4'd6, 4'd0, 1'b1, 2'b00, 1'b0, 32'h66, 32'd0);
    expect_w(1'b1, 4'd5, 32'h104, 1'b0, 1'b0); step(32'h12345678, "ldr_base");
    expect_w(1'b1, 4'd6, 32'h66, 1'b0, 1'b0); step(32'd0, "held_add_r6");

    // LDR with rd == rn: single write of load data
    drive(1'b1, 1'b0, 4'd4, 4'd4, 1'b1, 2'b01, 1'b1, 32'h999, 32'd0);
    expect_w(1'b1, 4'd4, 32'hCAFEF00D, 1'b0, 1'b0); step(32'hCAFEF00D, "ldr_same");
    bubble();
    expect_w(1'b0, 4'd4, 32'hCAFEF00D, 1'b0, 1'b0); step(32'h0BADF00D, "bubble_hold");

    // BL, MOV pc, reserved source, base-only write, no-write instruction
    drive(1'b1, 1'b0, 4'd14, 4'd0, 1'b1, 2'b10, 1'b0, 32'h1234, 32'h200);
    expect_w(1'b1, 4'd14, 32'h200, 1'b0, 1'b0); step(32'd0, "bl_link");
    drive(1'b1, 1'b0, 4'd15, 4'd0, 1'b1, 2'b00, 1'b0, 32'h80, 32'd0);
    expect_w(1'b1, 4'd15, 32'h80, 1'b0, 1'b0); step(32'd0, "mov_pc");
    drive(1'b1, 1'b0, 4'd7, 4'd0, 1'b1, 2'b11, 1'b0, 32'h77, 32'h55);
    expect_w(1'b1, 4'd7, 32'h77, 1'b0, 1'b0); step(32'hAA, "rsvd_src");
    drive(1'b1, 1'b0, 4'd1, 4'd9, 1'b0, 2'b01, 1'b1, 32'h900, 32'd0);
    expect_w(1'b1, 4'd9, 32'h900, 1'b0, 1'b0); step(32'hAB, "rn_only");
    drive(1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 2'b00, 1'b0, 32'h321, 32'd0);
    expect_w(1'b0, 4'd9, 32'h900, 1'b0, 1'b0); step(32'd0, "no_write");

    // Flush during BASE kills the held ADD r1
    drive(1'b1, 1'b0, 4'd8, 4'd10, 1'b1, 2'b01, 1'b1, 32'hA0, 32'd0);
    expect_w(1'b1, 4'd8, 32'h88, 1'b1, 1'b0); step(32'h88, "fb_ldr_rd");
    drive(1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 2'b00, 1'b0, 32'h11, 32'd0);
    expect_w(1'b1, 4'd10, 32'hA0, 1'b0, 1'b0); step(32'd0, "fb_ldr_base");
    drive(1'b1, 1'b1, 4'd1, 4'd0, 1'b1, 2'b00, 1'b0, 32'h11, 32'd0);
    expect_w(1'b0, 4'd10, 32'hA0, 1'b0, 1'b0); step(32'd0, "fb_killed");
    bubble();
    expect_w(1'b0, 4'd10, 32'hA0, 1'b0, 1'b0); step(32'd0, "fb_bubble");
    drive(1'b1, 1'b0, 4'd3, 4'd0, 1'b1, 2'b00, 1'b0, 32'h33, 32'd0);
    expect_w(1'b1, 4'd3, 32'h33, 1'b0, 1'b0); step(32'd0, "fb_after");

    // Flush with stall in RUN: capture after BASE is a bubble
    drive(1'b1, 1'b0, 4'd11, 4'd12, 1'b1, 2'b01, 1'b1, 32'hB0, 32'd0);
    expect_w(1'b1, 4'd11, 32'hBB, 1'b1, 1'b0); step(32'hBB, "fr_ldr_rd");
    drive(1'b1, 1'b1, 4'd1, 4'd0, 1'b1, 2'b00, 1'b0, 32'h11, 32'd0);
    expect_w(1'b1, 4'd12, 32'hB0, 1'b0, 1'b0); step(32'd0, "fr_ldr_base");
    drive(1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 2'b00, 1'b0, 32'h11, 32'd0);
    expect_w(1'b0, 4'd12, 32'hB0, 1'b0, 1'b0); step(32'd0, "fr_killed");
    drive(1'b1, 1'b0, 4'd2, 4'd0, 1'b1, 2'b00, 1'b0, 32'h22, 32'd0);
    expect_w(1'b1, 4'd2, 32'h22, 1'b0, 1'b0); step(32'd0, "fr_after");

    // Reset in the middle of a two-write instruction aborts the base write
    drive(1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 2'b01, 1'b1, 32'hC0, 32'd0);
    expect_w(1'b1, 4'd1, 32'hCC, 1'b1, 1'b0); step(32'hCC, "rb_ldr_rd");
    rst = 1'b1; bubble();
    expect_w(1'b0, 4'd0, 32'd0, 1'b0, 1'b1); step(32'd0, "rb_reset");
    rst = 1'b0;
    expect_w(1'b0, 4'd0, 32'd0, 1'b0, 1'b0); step(32'd0, "rb_aborted");
    drive(1'b1, 1'b0, 4'd5, 4'd0, 1'b1, 2'b00, 1'b0, 32'h55, 32'd0);
    expect_w(1'b1, 4'd5, 32'h55, 1'b0, 1'b0); step(32'd0, "rb_after");
    bubble();
    expect_w(1'b0, 4'd5, 32'h55, 1'b0, 1'b0); step(32'd0, "final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
